// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake/data bundle for nibble_serial_adder_ctrl.
//   master : operand producer / result consumer side (drives requests, accepts results)
//   slave  : the adder sequencer itself
// Signals:
//   start_valid/start_ready : operand handshake; a_in, b_in, cin_in sampled on accept
//   res_valid/res_ready     : result handshake; sum_out, cout_out, ovf_out qualified by res_valid
//   busy                    : sequencer not idle
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         ovf_out;
  logic         busy;

  modport master (
    output start_valid, a_in, b_in, cin_in, res_ready,
    input  start_ready, res_valid, sum_out, cout_out, ovf_out, busy
  );

  modport slave (
    input  start_valid, a_in, b_in, cin_in, res_ready,
    output start_ready, res_valid, sum_out, cout_out, ovf_out, busy
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// W-bit adder (W = 4*NIBBLES) built from one 4-bit ripple stage reused over successive
// nibbles, LSB nibble first. The inter-nibble carry lives in carry_q.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_adder_ctrl_if (operand and result handshakes)
// Latency: result valid NIBBLES cycles after the accept edge; issue interval NIBBLES+2.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave   bus
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [4:0]      nib_res;
  logic            last_nib;

  // The single shared 4-bit adder stage.
  always_comb begin
    a_nib    = a_q[4*idx_q +: 4];
    b_nib    = b_q[4*idx_q +: 4];
    nib_res  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    last_nib = (idx_q == IdxW'(NIBBLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            carry_q <= bus.cin_in;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          sum_q[4*idx_q +: 4] <= nib_res[3:0];
          carry_q             <= nib_res[4];
          idx_q               <= idx_q + 1'b1;
          if (last_nib) begin
            cout_q  <= nib_res[4];
            // nib_res[3] is the MSB of the full sum on the last nibble.
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (nib_res[3] != a_q[W-1]);
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.res_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs decode the state register only; no input-to-output paths.
  assign bus.start_ready = (state_q == StIdle);
  assign bus.res_valid   = (state_q == StDone);
  assign bus.busy        = (state_q != StIdle);
  assign bus.sum_out     = sum_q;
  assign bus.cout_out    = cout_q;
  assign bus.ovf_out     = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES = 4): directed vectors with literal
// expectations, plus a transaction-level model checked against the DUT every cycle.
module tb_nibble_serial_adder_ctrl;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request produces its result NIBBLES edges later;
  // the result is held until an edge with res_ready high.
  int          m_phase;    // 0 idle, 1 computing, 2 result presented
  int          m_elapsed;
  logic [15:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  logic [15:0] p_sum;
  logic        p_cout;
  logic        p_ovf;

  always @(posedge clk or negedge rst_n) begin : model
    logic [16:0] full;
    int          st;
    if (!rst_n) begin
      m_phase   <= 0;
      m_elapsed <= 0;
      m_sum     <= '0;
      m_cout    <= 1'b0;
      m_ovf     <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.start_valid) begin
        full = 17'(bus.a_in) + 17'(bus.b_in) + 17'(bus.cin_in);
        st   = int'($signed(bus.a_in)) + int'($signed(bus.b_in)) + int'(bus.cin_in);
        p_sum     <= full[15:0];
        p_cout    <= full[16];
        p_ovf     <= (st > 32767) || (st < -32768);
        m_phase   <= 1;
        m_elapsed <= 0;
      end
    end else if (m_phase == 1) begin
      m_elapsed <= m_elapsed + 1;
      if (m_elapsed + 1 == int'(NIBBLES)) begin
        m_phase <= 2;
        m_sum   <= p_sum;
        m_cout  <= p_cout;
        m_ovf   <= p_ovf;
      end
    end else if (bus.res_ready) begin
      m_phase <= 0;
    end
  end

  // Every-cycle comparison; sum/flags are only meaningful outside the compute phase.
  always @(negedge clk) begin
    check("m_start_ready", 32'(bus.start_ready), 32'(m_phase == 0));
    check("m_busy", 32'(bus.busy), 32'(m_phase != 0));
    check("m_res_valid", 32'(bus.res_valid), 32'(m_phase == 2));
    if (m_phase != 1) begin
      check("m_sum", 32'(bus.sum_out), 32'(m_sum));
      check("m_cout", 32'(bus.cout_out), 32'(m_cout));
      check("m_ovf", 32'(bus.ovf_out), 32'(m_ovf));
    end
  end

  // Issues a request and returns #1 after its accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    check("ready_before_start", 32'(bus.start_ready), 32'd1);
    bus.a_in        = a;
    bus.b_in        = b;
    bus.cin_in      = c;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.a_in        = ~a;  // later changes must not matter
    bus.b_in        = ~b;
    bus.cin_in      = ~c;
  endtask

  // Called #1 after an accept edge; checks latency and the literal result.
  task automatic wait_result(input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("sum", 32'(bus.sum_out), 32'(es));
    check("cout", 32'(bus.cout_out), 32'(ec));
    check("ovf", 32'(bus.ovf_out), 32'(eo));
  endtask

  task automatic release_res();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("idle_after_release", 32'(bus.start_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tests           = 0;
    fails           = 0;
    rst_n           = 1'b1;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;
    bus.cin_in      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_sum", 32'(bus.sum_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add.
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_result(16'h5555, 1'b0, 1'b0);
    release_res();

    // Carry ripples through every nibble.
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_result(16'h0000, 1'b1, 1'b0);
    release_res();

    // Signed overflow cases.
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_result(16'h8000, 1'b0, 1'b1);
    release_res();

    start_op(16'h9ABC, 16'hDEF0, 1'b1);
    wait_result(16'h79AD, 1'b1, 1'b1);
    release_res();

    // res_ready already high: result presented for exactly one cycle.
    bus.res_ready = 1'b1;
    start_op(16'h8000, 16'h8000, 1'b0);
    wait_result(16'h0000, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 32'(bus.res_valid), 32'd0);
    bus.res_ready = 1'b0;

    // Backpressure with a competing request pending.
    start_op(16'h1234, 16'h4321, 1'b0);
    wait_result(16'h5555, 1'b0, 1'b0);
    bus.a_in        = 16'h0F0F;
    bus.b_in        = 16'h00F1;
    bus.cin_in      = 1'b0;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check("bp_start_ready", 32'(bus.start_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
      check("bp_sum", 32'(bus.sum_out), 32'h5555);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("bp_idle", 32'(bus.start_ready), 32'd1);
    check("bp_valid_low", 32'(bus.res_valid), 32'd0);
    @(posedge clk);  // new operands accepted here
    #1;
    bus.start_valid = 1'b0;
    check("bp_accepted", 32'(bus.busy), 32'd1);
    wait_result(16'h1000, 1'b0, 1'b0);
    release_res();

    // Reset during the second compute cycle aborts the operation.
    start_op(16'hAAAA, 16'h5555, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_start_ready", 32'(bus.start_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    check("abort_sum", 32'(bus.sum_out), 32'd0);
    check("abort_cout", 32'(bus.cout_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_result", 32'(bus.res_valid), 32'd0);
    end
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_result(16'h0002, 1'b0, 1'b0);
    release_res();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
